pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage AArch64 pipeline. Drives en/clr of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. Resolves load-use,

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_hz_lat_cnt.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef logic       u1;
  typedef logic [4:0] u5;

  localparam u5           XZR   = 5'd31;
  localparam int unsigned LAT_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    u1 en;
    u1 clr;
  } stage_ctrl_t;

  // Load in EX feeding a valid ID source; the zero register never forwards a value.
  function automatic u1 load_use(input u1 is_load, input u5 rd,
                                 input u1 rs1_v, input u5 rs1,
                                 input u1 rs2_v, input u5 rs2);
    return is_load && (rd != XZR) &&
           ((rs1_v && (rs1 == rd)) || (rs2_v && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_lat_cnt.sv
// Loadable down-counter; done marks the final counted cycle (value 1).
module pipe_hazard_ctrl_hz_lat_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: pipe-reg enables, bubbles,
// deferred branch redirects and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ireq_stall,
  input  logic             dreq_stall,
  input  logic             ex_multi,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_v,
  input  logic             id_rs2_v,
  input  logic             redirect,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             clr_d,
  output logic             clr_e,
  output logic             clr_m,
  output logic             clr_w,
  output logic             redirect_go,
  output logic             busy_multi,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t state;
  logic        pend_redir;
  logic        mul_done;
  logic        multi_start;
  logic        hold_ex;
  logic        redir_taken;
  logic        en_pc;
  stage_ctrl_t d_ctrl, e_ctrl, m_ctrl, w_ctrl;

  assign multi_start = (state == RUN) && ex_multi && !dreq_stall;
  // Start cycle counts toward occupancy, so EX is held MUL_LAT-1 cycles in total.
  assign hold_ex     = ((state == MULTI) && !mul_done) || ((state == RUN) && ex_multi);

  pipe_hazard_ctrl_hz_lat_cnt #(.W(LAT_W)) u_mul_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (multi_start),
    .load_val (LAT_W'(MUL_LAT - 1)),
    .done     (mul_done)
  );

  // Priority-ordered stage control; first matching condition wins.
  always_comb begin
    en_pc       = 1'b1;
    d_ctrl      = '{en: 1'b1, clr: 1'b0};
    e_ctrl      = '{en: 1'b1, clr: 1'b0};
    m_ctrl      = '{en: 1'b1, clr: 1'b0};
    w_ctrl      = '{en: 1'b1, clr: 1'b0};
    redirect_go = 1'b0;
    redir_taken = 1'b0;
    if (rst) begin
      en_pc  = 1'b0;
      d_ctrl = '0;
      e_ctrl = '0;
      m_ctrl = '0;
      w_ctrl = '0;
    end else if (dreq_stall) begin
      en_pc      = 1'b0;
      d_ctrl.en  = 1'b0;
      e_ctrl.en  = 1'b0;
      m_ctrl.en  = 1'b0;
      w_ctrl.clr = 1'b1;
    end else if (hold_ex) begin
      en_pc      = 1'b0;
      d_ctrl.en  = 1'b0;
      e_ctrl.en  = 1'b0;
      m_ctrl.clr = 1'b1;
    end else if (redirect || pend_redir) begin
      redirect_go = 1'b1;
      redir_taken = 1'b1;
      d_ctrl.clr  = 1'b1;
      e_ctrl.clr  = 1'b1;
    end else if (load_use(ex_is_load, ex_rd, id_rs1_v, id_rs1, id_rs2_v, id_rs2)) begin
      en_pc      = 1'b0;
      d_ctrl.en  = 1'b0;
      e_ctrl.clr = 1'b1;
    end else if (ireq_stall) begin
      en_pc      = 1'b0;
      d_ctrl.clr = 1'b1;
    end
  end

  // State, deferred redirect and perf counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pend_redir   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        RUN:     if (multi_start) state <= MULTI;
        MULTI:   if (mul_done)    state <= RUN;
        default:                  state <= RUN;
      endcase
      if ((dreq_stall || hold_ex) && redirect) pend_redir <= 1'b1;
      else if (redir_taken)                    pend_redir <= 1'b0;
      if (!e_ctrl.en) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign en_f       = en_pc;
  assign en_d       = d_ctrl.en;
  assign clr_d      = d_ctrl.clr;
  assign en_e       = e_ctrl.en;
  assign clr_e      = e_ctrl.clr;
  assign en_m       = m_ctrl.en;
  assign clr_m      = m_ctrl.clr;
  assign en_w       = w_ctrl.en;
  assign clr_w      = w_ctrl.clr;
  assign busy_multi = (state == MULTI);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against an occupancy-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W   = 32;

  typedef struct {
    bit       rst, ireq, dreq, multi, is_load, redir, v1, v2;
    bit [4:0] rd, rs1, rs2;
  } stim_t;

  logic clk = 1'b0;
  logic rst, ireq_stall, dreq_stall, ex_multi, ex_is_load, id_rs1_v, id_rs2_v, redirect;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, redirect_go, busy_multi;
  logic [CNT_W-1:0] stall_cycles;
  logic [9:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: EX cycles left in the current multi-cycle op, owed redirect, stall total.
  int unsigned      ref_left;
  bit               ref_owed;
  logic [CNT_W-1:0] ref_stalls;

  always #5 clk = ~clk;

  assign obs = {en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w, redirect_go};

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ireq_stall(ireq_stall), .dreq_stall(dreq_stall),
    .ex_multi(ex_multi), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_v(id_rs1_v), .id_rs2_v(id_rs2_v),
    .redirect(redirect), .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m), .clr_w(clr_w),
    .redirect_go(redirect_go), .busy_multi(busy_multi), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; ireq_stall = s.ireq; dreq_stall = s.dreq; ex_multi = s.multi;
    ex_is_load = s.is_load; redirect = s.redir; id_rs1_v = s.v1; id_rs2_v = s.v2;
    ex_rd = s.rd; id_rs1 = s.rs1; id_rs2 = s.rs2;
  endtask

  // One clock: apply stimulus, compare against the model, then advance the model.
  task automatic step(input stim_t s);
    bit       hazard, ex_held, flushed;
    bit       f, d, cd, e, ce, m, cm, w, cw, go;
    @(posedge clk);
    #1 drive(s);
    #1;
    hazard  = s.is_load && s.rd != 5'd31 &&
              ((s.v1 && s.rs1 == s.rd) || (s.v2 && s.rs2 == s.rd));
    ex_held = (ref_left > 1) || (ref_left == 0 && s.multi);
    {f, d, cd, e, ce, m, cm, w, cw, go} = 10'b1101010100;
    flushed = 1'b0;
    if (s.rst)                     {f, d, cd, e, ce, m, cm, w, cw, go} = '0;
    else if (s.dreq)               begin f = 0; d = 0; e = 0; m = 0; cw = 1; end
    else if (ex_held)              begin f = 0; d = 0; e = 0; cm = 1; end
    else if (s.redir || ref_owed)  begin go = 1; cd = 1; ce = 1; flushed = 1; end
    else if (hazard)               begin f = 0; d = 0; ce = 1; end
    else if (s.ireq)               begin f = 0; cd = 1; end
    check("ctrl", 64'(obs), 64'({f, d, cd, e, ce, m, cm, w, cw, go}));
    check("busy_multi", 64'(busy_multi), 64'(ref_left > 0));
    check("stall_cycles", 64'(stall_cycles), 64'(ref_stalls));
    if (s.rst) begin
      ref_left = 0; ref_owed = 0; ref_stalls = '0;
    end else begin
      if (!e) ref_stalls = ref_stalls + 1'b1;
      if ((s.dreq || ex_held) && s.redir) ref_owed = 1;
      else if (flushed)                   ref_owed = 0;
      if (ref_left > 0)                   ref_left = ref_left - 1;
      else if (s.multi && !s.dreq)        ref_left = MUL_LAT - 1;
    end
  endtask

  initial begin
    stim_t s;
    int    go_cnt;
    logic [CNT_W-1:0] s0;

    ref_left = 0; ref_owed = 0; ref_stalls = '0;
    s = idle(); s.rst = 1;
    drive(s);
    @(posedge clk);

    // Reset held with other inputs toggling.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rst = 1; s.dreq = 1'(i); s.redir = 1; s.multi = 1'(i + 1); s.ireq = 1;
      step(s);
      check("rst_ctrl_zero", 64'(obs), 64'd0);
    end
    step(idle());
    check("post_rst_all_en", 64'(obs), 64'(10'b1101010100));

    // Load-use on x3, then the same shape on XZR.
    s = idle(); s.is_load = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.v1 = 1;
    step(s);
    check("load_use_stall", 64'({en_f, en_d, clr_e}), 64'(3'b001));
    step(idle());
    s.rd = 5'd31; s.rs1 = 5'd31; s.rs2 = 5'd31; s.v2 = 1;
    step(s);
    check("xzr_no_stall", 64'({en_f, en_d, clr_e}), 64'(3'b110));

    // Multi-cycle EX op.
    s0 = stall_cycles;
    s = idle(); s.multi = 1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      check("multi_hold", 64'({en_e, clr_m}), 64'(2'b01));
    end
    step(s);
    check("multi_release", 64'({en_f, en_d, en_e, en_m, en_w}), 64'(5'b11111));
    step(idle());
    check("multi_stall_delta", 64'(stall_cycles - s0), 64'd3);

    // Redirect deferred behind a MEM stall.
    go_cnt = 0;
    s = idle(); s.redir = 1; s.dreq = 1;
    for (int i = 0; i < 5; i++) begin
      step(s);
      go_cnt += int'(redirect_go);
    end
    s.dreq = 0;
    step(s);
    check("redir_after_stall", 64'({redirect_go, clr_d, clr_e}), 64'(3'b111));
    go_cnt += int'(redirect_go);
    step(idle());
    go_cnt += int'(redirect_go);
    check("redir_once", 64'(go_cnt), 64'd1);

    // ireq_stall with and without a redirect.
    s = idle(); s.ireq = 1; s.redir = 1;
    step(s);
    check("ireq_redir", 64'({en_f, redirect_go, clr_d}), 64'(3'b111));
    s.redir = 0;
    step(s);
    check("ireq_alone", 64'({en_f, clr_d}), 64'(2'b01));

    // Reset part-way through a multi-cycle op with a redirect pending.
    s = idle(); s.multi = 1; s.redir = 1;
    step(s);
    step(s);
    s = idle(); s.rst = 1;
    step(s);
    step(idle());
    check("rst_multi_busy", 64'(busy_multi), 64'd0);
    check("rst_multi_no_redir", 64'(redirect_go), 64'd0);

    // Randomized traffic biased toward hazards.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pick;
      s = idle();
      s.rst     = ($urandom_range(0, 63) == 0);
      s.ireq    = ($urandom_range(0, 4) == 0);
      s.dreq    = ($urandom_range(0, 4) == 0);
      s.multi   = ($urandom_range(0, 7) == 0);
      s.is_load = ($urandom_range(0, 2) == 0);
      s.redir   = ($urandom_range(0, 9) == 0);
      s.v1      = 1'($urandom);
      s.v2      = 1'($urandom);
      pick = $urandom_range(0, 4); s.rd  = (pick == 4) ? 5'd31 : 5'(pick);
      pick = $urandom_range(0, 4); s.rs1 = (pick == 4) ? 5'd31 : 5'(pick);
      pick = $urandom_range(0, 4); s.rs2 = (pick == 4) ? 5'd31 : 5'(pick);
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
